// File: rtl/line_burst_adaptor_pkg.sv
// Shared cache-side types for the line burst adaptor: FSM states, beat geometry
// and the line-alignment helper.
package line_burst_adaptor_pkg;

  localparam int LINE_W      = 256;
  localparam int BURST_W     = 64;
  localparam int ADDR_W      = 32;
  localparam int BEATS       = LINE_W / BURST_W;
  localparam int BEAT_IDX_W  = $clog2(BEATS);
  localparam int BEAT_LSB_W  = $clog2(BURST_W);
  localparam int LINE_OFS_W  = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lba_state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    line_align = {addr[ADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/line_burst_adaptor_beat.sv
// Beat index counter for one line burst: clear/advance with a last-beat flag.
module line_beat_counter
  import line_burst_adaptor_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [BEAT_IDX_W-1:0] cnt,
  output logic                  last
);

  logic [BEAT_IDX_W-1:0] cnt_r;

  // beat index; wraps naturally to 0 after the last beat
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= {BEAT_IDX_W{1'b0}};
    end else if (advance) begin
      cnt_r <= cnt_r + BEAT_IDX_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign last = (cnt_r == BEAT_IDX_W'(BEATS - 1));

endmodule

// File: rtl/line_burst_adaptor.sv
// Cache line <-> 4-beat memory burst adaptor.
// Optional stall watchdog enabled by defining LINE_BURST_WDOG_EN.
module line_burst_adaptor
  import line_burst_adaptor_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [ADDR_W-1:0]  pmem_address,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic               burst_read,
  output logic               burst_write,
  output logic [ADDR_W-1:0]  burst_addr,
  output logic [BURST_W-1:0] burst_wdata,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp,
  output logic               burst_err
);

  lba_state_t             state_r;
  lba_state_t             state_s;
  logic [LINE_W-1:0]      buf_r;
  logic [LINE_W-1:0]      pmem_rdata_r;
  logic [LINE_W-1:0]      line_next_s;
  logic [ADDR_W-1:0]      burst_addr_r;
  logic [BEAT_IDX_W-1:0]  cnt_s;
  logic                   last_s;
  logic                   in_burst_s;
  logic                   advance_s;
  logic                   timeout_s;
  logic                   burst_err_s;
  logic [7:0]             beat_ofs_s;

  assign in_burst_s = (state_r == RD) || (state_r == WR);
  assign advance_s  = in_burst_s && burst_resp;
  assign beat_ofs_s = 8'({cnt_s, {BEAT_LSB_W{1'b0}}});

  line_beat_counter u_beat (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_r == IDLE),
    .advance (advance_s),
    .cnt     (cnt_s),
    .last    (last_s)
  );

`ifdef LINE_BURST_WDOG_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_r;
  logic              burst_err_r;

  // cycles since the memory last moved a beat
  always_ff @(posedge clk) begin
    if (rst || (state_r == IDLE) || burst_resp) begin
      wait_r <= {WAIT_W{1'b0}};
    end else if (in_burst_s) begin
      wait_r <= wait_r + WAIT_W'(1);
    end else begin
      wait_r <= wait_r;
    end
  end

  assign timeout_s = in_burst_s && !burst_resp && (wait_r == WAIT_W'(TIMEOUT - 1));

  // sticky timeout flag, only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_err_r <= 1'b0;
    end else if (timeout_s) begin
      burst_err_r <= 1'b1;
    end else begin
      burst_err_r <= burst_err_r;
    end
  end

  assign burst_err_s = burst_err_r;
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT);
  assign timeout_s        = 1'b0;
  assign burst_err_s      = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next state; write wins over read in IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pmem_write) begin
          state_s = WR;
        end else if (pmem_read) begin
          state_s = RD;
        end else begin
          state_s = IDLE;
        end
      end
      RD, WR: begin
        if ((burst_resp && last_s) || timeout_s) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // line buffer with the current read beat merged in
  always_comb begin
    line_next_s = buf_r;
    line_next_s[beat_ofs_s +: BURST_W] = burst_rdata;
  end

  // request latch, beat capture and completed read line
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_r        <= {LINE_W{1'b0}};
      pmem_rdata_r <= {LINE_W{1'b0}};
      burst_addr_r <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pmem_write) begin
            burst_addr_r <= line_align(pmem_address);
            buf_r        <= pmem_wdata;
          end else if (pmem_read) begin
            burst_addr_r <= line_align(pmem_address);
          end
        end
        RD: begin
          if (burst_resp) begin
            buf_r <= line_next_s;
            if (last_s) begin
              pmem_rdata_r <= line_next_s;
            end
          end
        end
        default: begin
          buf_r <= buf_r;
        end
      endcase
    end
  end

  assign pmem_rdata  = pmem_rdata_r;
  assign pmem_resp   = (state_r == DONE);
  assign burst_read  = (state_r == RD);
  assign burst_write = (state_r == WR);
  assign burst_addr  = burst_addr_r;
  assign burst_wdata = buf_r[beat_ofs_s +: BURST_W];
  assign burst_err   = burst_err_s;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Scoreboard bench for line_burst_adaptor with a zero-wait burst memory model.
// Define LINE_BURST_WDOG_EN to also exercise the watchdog (TIMEOUT = 8).
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp, burst_read, burst_write, burst_resp, burst_err;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_wdata, burst_rdata;

  typedef struct {
    bit           is_read;
    logic [255:0] line;
  } resp_t;

  resp_t        rq[$];
  logic [63:0]  wq[$];
  resp_t        item;
  int           tests_run = 0;
  int           tests_failed = 0;
  int           resp_seen = 0;
  int           exp_resps = 0;
  int           model_beat = 0;
  int           stall_beat = -1;
  int           stall_left = 0;
  bit           mem_dead = 1'b0;
  bit           saw_read = 1'b0;
  bit           prev_resp = 1'b0;
  logic [255:0] rd_line = '0;
  logic [31:0]  exp_addr = '0;

  line_burst_adaptor #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .burst_read(burst_read), .burst_write(burst_write),
    .burst_addr(burst_addr), .burst_wdata(burst_wdata), .burst_rdata(burst_rdata),
    .burst_resp(burst_resp), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory model: answers on the falling edge so the DUT samples it on the next rising edge
  always @(negedge clk) begin
    if (burst_read) saw_read = 1'b1;
    if (!(burst_read || burst_write)) begin
      model_beat = 0;
      burst_resp = 1'b0;
    end else if (mem_dead) begin
      burst_resp = 1'b0;
    end else if (model_beat == stall_beat && stall_left > 0) begin
      burst_resp = 1'b0;
      stall_left--;
    end else begin
      burst_resp = 1'b1;
      if (burst_read) burst_rdata = rd_line[model_beat*64 +: 64];
      if (burst_write) begin
        if (wq.size() == 0) check("wbeat_unexpected", 1, 0);
        else check("wdata", burst_wdata, wq.pop_front());
        check("waddr", burst_addr, exp_addr);
      end
      model_beat++;
    end
  end

  // response monitor: one-cycle pulse, read line against the scoreboard
  always @(negedge clk) begin
    if (pmem_resp) begin
      resp_seen++;
      check("resp_pulse", prev_resp, 1'b0);
      if (rq.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        item = rq.pop_front();
        if (item.is_read) check("rdata", pmem_rdata, item.line);
      end
    end
    prev_resp = pmem_resp;
  end

  // called at a falling edge; request cycle counts as 1
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wline, input int exp_lat, input string tag);
    int lat;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wline;
    lat = 1;
    while (!pmem_resp && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    check(tag, lat, exp_lat);
    repeat (2) @(negedge clk);
  endtask

  task automatic push_write(input logic [255:0] line);
    for (int i = 0; i < 4; i++) wq.push_back(line[i*64 +: 64]);
    rq.push_back('{1'b0, '0});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [255:0] wl;
    rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = '0; pmem_wdata = '0; burst_resp = 1'b0; burst_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_resp", pmem_resp, 0);
    check("rst_bread", burst_read, 0);
    check("rst_bwrite", burst_write, 0);
    check("rst_baddr", burst_addr, 0);
    check("rst_rdata", pmem_rdata, 0);
    check("rst_wdata", burst_wdata, 0);
    check("rst_err", burst_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-wait read
    rd_line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    rq.push_back('{1'b1, rd_line}); exp_resps++;
    run_req(1'b1, 1'b0, 32'h0000_1040, '0, 6, "rd_latency");

    // 2: write, unaligned address
    wl = {64'hD3D3_0000_3333_0003, 64'hD2D2_0000_2222_0002,
          64'hD1D1_0000_1111_0001, 64'hD0D0_0000_0000_0000};
    exp_addr = 32'h1234_5660;
    push_write(wl); exp_resps++;
    run_req(1'b0, 1'b1, 32'h1234_5677, wl, 6, "wr_latency");
    check("wr_drain", wq.size(), 0);

    // 3: read with a 3-cycle stall before beat 2
    rd_line = {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444,
               64'hCAFE_F00D_0000_0001, 64'hDEAD_BEEF_0BAD_F00D};
    stall_beat = 2; stall_left = 3;
    rq.push_back('{1'b1, rd_line}); exp_resps++;
    run_req(1'b1, 1'b0, 32'h8000_00E0, '0, 9, "stall_latency");
    stall_beat = -1;

    // 4: read and write together, write wins
    saw_read = 1'b0;
    wl = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
    exp_addr = 32'h0000_0100;
    push_write(wl); exp_resps++;
    run_req(1'b1, 1'b1, 32'h0000_011F, wl, 6, "both_latency");
    check("both_no_read", saw_read, 0);
    check("both_drain", wq.size(), 0);

    // 5: reset after beat 1 of a write
    wl = {64'hEE03, 64'hEE02, 64'hEE01, 64'hEE00};
    exp_addr = 32'h0000_2000;
    push_write(wl);
    pmem_write = 1'b1; pmem_address = 32'h0000_2004; pmem_wdata = wl;
    repeat (3) @(negedge clk);
    rst = 1'b1; pmem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_bwrite", burst_write, 0);
    check("abort_bread", burst_read, 0);
    check("abort_resp", pmem_resp, 0);
    check("abort_baddr", burst_addr, 0);
    check("abort_wdata", burst_wdata, 0);
    check("abort_rdata", pmem_rdata, 0);
    wq.delete();
    rq.delete();
    repeat (3) @(negedge clk);
    rd_line = {64'h0F0F_0003, 64'h0F0F_0002, 64'h0F0F_0001, 64'h0F0F_0000};
    rq.push_back('{1'b1, rd_line}); exp_resps++;
    run_req(1'b1, 1'b0, 32'h0000_3000, '0, 6, "post_abort_latency");

`ifdef LINE_BURST_WDOG_EN
    // 6: memory never answers, watchdog completes the burst
    mem_dead = 1'b1;
    rq.push_back('{1'b0, '0}); exp_resps++;
    run_req(1'b1, 1'b0, 32'h0000_4000, '0, 10, "wdog_latency");
    check("wdog_err_set", burst_err, 1);
    repeat (5) @(negedge clk);
    check("wdog_err_held", burst_err, 1);
    mem_dead = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("wdog_err_clr", burst_err, 0);
`else
    check("err_off", burst_err, 0);
`endif

    repeat (3) @(negedge clk);
    check("resp_count", resp_seen, exp_resps);
    check("sb_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
